// File: rtl/cnn_stream_pkg.sv
// ============================================================================
// Module : cnn_stream_pkg
// Brief  : Shared types and helpers for the CNN pixel-stream blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } streamer_state_t;

  // Side length of the streamed frame including the zero border.
  function automatic int frame_width(input int image_width, input int padding);
    return image_width + 2 * padding;
  endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
// Module : raster_counter
// Brief  : Row-major (row,col) position counter over a Width x Width frame.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter #(
  parameter  int Width = 4,
  localparam int CW    = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(Width - 1));
  assign row_end = (row_q == CW'(Width - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        // Advancing past the final pixel wraps back to the frame origin.
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = row_end & col_end;

endmodule

`default_nettype wire

// File: rtl/image_streamer.sv
// ============================================================================
// Module : image_streamer
// Brief  : Stores an ImageWidth^2 image and streams it, optionally zero-padded,
//          over a valid/ready pixel interface with a registered output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_streamer
  import cnn_stream_pkg::*;
#(
  parameter  int BitSize    = 4,
  parameter  int ImageWidth = 4,
  parameter  int Padding    = 0,
  localparam int AW         = $clog2(ImageWidth * ImageWidth),
  localparam int FW         = frame_width(ImageWidth, Padding),
  localparam int CW         = $clog2(FW)
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [BitSize-1:0] wr_data,
  input  logic               start,
  input  logic               in_ready,
  output logic               out_valid,
  output logic [BitSize-1:0] out_data,
  output logic               busy,
  output logic               frame_done
);

  streamer_state_t    state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [BitSize-1:0] out_data_q, out_data_d;
  logic [BitSize-1:0] mem_q [ImageWidth*ImageWidth];

  logic               xfer;
  logic               wr_go;
  logic               cnt_clear;
  logic               cnt_advance;
  logic [CW-1:0]      row;
  logic [CW-1:0]      col;
  logic               last;
  logic [CW-1:0]      fetch_row;
  logic [CW-1:0]      fetch_col;
  logic [AW-1:0]      fetch_idx;
  logic               fetch_in_img;
  logic [BitSize-1:0] fetch_pixel;
  int                 img_r;
  int                 img_c;

  assign xfer  = out_valid_q & in_ready;
  assign wr_go = (state_q == IDLE) & wr_en &
                 ({1'b0, wr_addr} < (AW+1)'(ImageWidth * ImageWidth));

  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  raster_counter #(
    .Width (FW)
  ) u_raster_counter (
    .clk     (clk),
    .res_n   (res_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // Fetch address: frame origin when launching, otherwise the pixel after (row,col).
  always_comb begin
    fetch_row = '0;
    fetch_col = '0;
    if (state_q != IDLE) begin
      if (col == CW'(FW - 1)) begin
        fetch_row = row + 1'b1;
        fetch_col = '0;
      end else begin
        fetch_row = row;
        fetch_col = col + 1'b1;
      end
    end
  end

  always_comb begin
    img_r        = int'(fetch_row) - Padding;
    img_c        = int'(fetch_col) - Padding;
    fetch_in_img = (img_r >= 0) && (img_r < ImageWidth) &&
                   (img_c >= 0) && (img_c < ImageWidth);
    fetch_idx    = fetch_in_img ? AW'(img_r * ImageWidth + img_c) : '0;
    fetch_pixel  = fetch_in_img ? mem_q[fetch_idx] : '0;
    // A write landing in the launch cycle must be visible in the first pixel.
    if (fetch_in_img && wr_go && (wr_addr == fetch_idx)) begin
      fetch_pixel = wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          out_valid_d = 1'b1;
          out_data_d  = fetch_pixel;
          cnt_clear   = 1'b1;
        end
      end
      STREAM: begin
        if (xfer) begin
          cnt_advance = 1'b1;
          if (last) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
          end else begin
            out_data_d  = fetch_pixel;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_image_streamer.sv
// ============================================================================
// Module : tb_image_streamer
// Brief  : Directed, table-driven bench for image_streamer (Padding 0 and 1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_streamer;

  logic       clk = 1'b0;
  logic       res_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       start;
  logic       start_p;
  logic       in_ready;

  logic       ov, busy, fd;
  logic [3:0] od;
  logic       pov, pbusy, pfd;
  logic [3:0] pod;

  always #5 clk = ~clk;

  image_streamer #(.BitSize(4), .ImageWidth(4), .Padding(0)) dut (
    .clk(clk), .res_n(res_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .in_ready(in_ready), .out_valid(ov), .out_data(od),
    .busy(busy), .frame_done(fd)
  );

  image_streamer #(.BitSize(4), .ImageWidth(4), .Padding(1)) dut_pad (
    .clk(clk), .res_n(res_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_p), .in_ready(in_ready), .out_valid(pov), .out_data(pod),
    .busy(pbusy), .frame_done(pfd)
  );

  typedef struct {
    logic       rdy;
    logic       st;
    logic       we;
    logic [3:0] wd;
    logic       ev;
    logic [3:0] ed;
    logic       eb;
    logic       efd;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] img [16];
  logic [3:0] got [$];
  int         checks = 0;
  int         fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic st, input logic we, input logic [3:0] wd,
                     input logic ev, input logic [3:0] ed, input logic eb, input logic efd);
    vec_t v;
    v.rdy = rdy; v.st = st; v.we = we; v.wd = wd;
    v.ev = ev; v.ed = ed; v.eb = eb; v.efd = efd;
    tbl.push_back(v);
  endtask

  // Idle cycle issuing start, 16 back-to-back pixels, DONE, then idle.
  task automatic add_frame(input logic [3:0] first);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(1, 0, 0, 0, 1, (k == 0) ? first : img[k], 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // At negedge i: compare the outputs against entry i, then drive entry i's inputs.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d].ctl", name, i), {29'd0, ov, busy, fd},
            {29'd0, tbl[i].ev, tbl[i].eb, tbl[i].efd});
      if (tbl[i].ev) check($sformatf("%s[%0d].data", name, i), {28'd0, od}, {28'd0, tbl[i].ed});
      in_ready = tbl[i].rdy;
      start    = tbl[i].st;
      wr_en    = tbl[i].we;
      wr_addr  = 4'd0;
      wr_data  = tbl[i].wd;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    tbl.delete();
  endtask

  initial begin
    int k;
    int done_cnt;
    img = '{4'h7, 4'h2, 4'h2, 4'hF, 4'h8, 4'h8, 4'hF, 4'h7,
            4'hF, 4'h2, 4'h8, 4'h8, 4'hF, 4'h8, 4'h8, 4'h8};
    res_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_p = 1'b0; in_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.main", {28'd0, ov, busy, fd, |od}, 32'd0);
    check("reset.pad",  {28'd0, pov, pbusy, pfd, |pod}, 32'd0);
    res_n = 1'b0;

    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = img[a];
    end
    @(negedge clk);
    wr_en = 1'b0;

    // Padding=1: 36 transfers with a zero border
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (pov && in_ready) got.push_back(pod);
      if (pfd) done_cnt++;
      @(negedge clk);
    end
    check("pad.count", got.size(), 36);
    check("pad.done_pulses", done_cnt, 1);
    if (got.size() == 36) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          logic [3:0] e;
          e = (r < 1 || r > 4 || c < 1 || c > 4) ? 4'h0 : img[(r-1)*4 + (c-1)];
          check($sformatf("pad.px[%0d]", r*6+c), {28'd0, got[r*6+c]}, {28'd0, e});
        end
      end
      check("pad.idx7",  {28'd0, got[7]},  32'h7);
      check("pad.idx28", {28'd0, got[28]}, 32'h8);
    end

    // Full-rate frame
    add_frame(img[0]);
    run_table("full");

    // in_ready toggling 1,0,1,0: stalled cycles must hold the same pixel
    add(1, 1, 0, 0, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; k < 16; i++) begin
      add((i % 2) == 0, 0, 0, 0, 1, img[k], 1, 0);
      if ((i % 2) == 0) k++;
    end
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    run_table("stall");

    // start and a write to addr 0 mid-frame are ignored; next frame starts with 7
    add(1, 1, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) add(1, j == 5, j == 5, 4'h0, 1, img[j], 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add_frame(img[0]);
    run_table("midframe");

    // Write and start in the same idle cycle: first pixel shows the new value
    add(1, 1, 1, 4'h9, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) add(1, 0, 0, 0, 1, (j == 0) ? 4'h9 : img[j], 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 4'h7, 0, 0, 0, 0);
    add_frame(img[0]);
    run_table("wr_start");

    // Reset asserted while transfer 5 is presented
    @(negedge clk);
    in_ready = 1'b1; start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("rst.pre[%0d]", j), {27'd0, ov, od}, {27'd0, 1'b1, img[j]});
    end
    res_n = 1'b1;
    @(negedge clk);
    res_n = 1'b0;
    check("rst.after", {28'd0, ov, busy, fd, |od}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fd || busy || ov) done_cnt++;
    end
    check("rst.quiet", done_cnt, 0);
    add_frame(img[0]);
    run_table("rst.replay");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
